lf_sum_stage: RTL and testbench
===============================

// Module: lf_sum_stage
// PURPOSE
//  Final stage of the 64-bit Ladner-Fischer adder.
//  - Consumes the prefix network's group generate/propagate vectors (span: bit 0..i) and the bitwise half-sum h = a ^ b.
//  - Forms the carries, sum and flags.
//  - Registers the result behind a 2-entry valid/ready output buffer, so the adder streams one op per cycle under backpressure.
// PARAMETERS
//  WIDTH   64  operand width; any value >= 2 is legal.
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      prefix outputs + h + cin valid this cycle
//  in_ready   out  1      stage can accept; transfer = in_valid & in_ready
//  g_pfx      in   WIDTH  group generate, bits 0..i
//  p_pfx      in   WIDTH  group propagate, bits 0..i
//  h          in   WIDTH  bitwise a ^ b
//  cin        in   1      carry-in
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts; transfer = out_valid & out_ready
//  sum        out  WIDTH  a + b + cin, modulo 2^WIDTH
//  cout       out  1      carry out of the MSB
//  ovf        out  1      signed overflow
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - Carries (combinational, from inputs):
//      c[0] = cin
//      c[i] = g_pfx[i-1] | (p_pfx[i-1] & cin), for i = 1..WIDTH
//  - Results:
//      sum[i] = h[i] ^ c[i]
//      cout   = c[WIDTH]
//      ovf    = c[WIDTH] ^ c[WIDTH-1]
//      zero   = ~|sum
//  - Buffer:
//      - 2-entry FIFO of {sum,cout,ovf,zero}.
//      - occupancy cnt in 0..2.
//      - in_ready = rst_n & (cnt != 2).
//  - Latency: an op accepted on edge N is presented on the outputs right after edge N when the buffer was empty. Otherwise it is presented once older entries drain. Order is strictly preserved.
//  - Outputs always show the head entry. While out_valid & ~out_ready, sum/cout/ovf/zero are held stable.
//  - Simultaneous push and pop (cnt == 1): cnt stays 1 and the head advances to the new entry. Empty, push only: cnt -> 1. Full: no push possible.
//  - out_valid = (cnt != 0).
//  - Reset (async assert, sync-safe deassert; entries any cycle, including mid-stream):
//      - cnt = 0, out_valid = 0, sum = 0, cout = ovf = zero = 0, in_ready = 0 while rst_n is low.
//      - Buffered results are discarded.
//      - First transfer is possible in the first cycle after deassertion.
//  - No combinational path from out_ready to in_ready. in_ready depends only on registered cnt.
// STRUCTURE
//  - Package lf_adder_pkg:
//      - LF_WIDTH = 64.
//      - typedef lf_result_t {sum, cout, ovf, zero}.
//      - function lf_carries(g_pfx, p_pfx, cin).
//  - Sub-module lf_skid_fifo2 (2-entry register FIFO, generic payload width): holds the valid/ready and occupancy logic. The top holds the carry/sum/flag logic.
// TESTING (WIDTH=8 unless noted)
//  1. a=0xFF, b=0x01, cin=0: h=0xFE, g_pfx=0xFF, p_pfx=0x00, out_ready=1.
//     -> next cycle out_valid=1, sum=0x00, cout=1, ovf=0, zero=1.
//  2. a=0x7F, b=0x01, cin=0: h=0x7E, g_pfx=0x7F, p_pfx=0x00.
//     -> sum=0x80, cout=0, ovf=1, zero=0.
//  3. a=0x0F, b=0xF0, cin=1: h=0xFF, g_pfx=0x00, p_pfx=0xFF.
//     -> sum=0x00, cout=1, ovf=0, zero=1.
//  4. Backpressure: out_ready=0, three back-to-back valid ops.
//     -> two accepted, in_ready=0 on the third, head stable.
//     -> raise out_ready: results emerge in order, third accepted the cycle after the first pop.
//  5. Streaming: in_valid=out_ready=1 for 100 random ops.
//     -> one result per cycle, all match a reference a+b+cin model, cnt never reaches 2.
//  6. Reset mid-stream with cnt=2: assert rst_n=0 asynchronously.
//     -> out_valid and in_ready fall immediately, sum=0.
//     -> after release, stale data never reappears and a new op completes normally.

Source files
------------

// File: rtl/lf_adder_pkg.sv
// Shared definitions for the Ladner-Fischer adder: default width, result record
// and the carry-recovery helper used by the final sum stage.
package lf_adder_pkg;

    localparam int LF_WIDTH = 64;

    typedef struct packed {
        logic [LF_WIDTH-1:0] sum;
        logic                cout;
        logic                ovf;
        logic                zero;
    } lf_result_t;

    // Bit i+1 is the carry into bit i+1 (group span 0..i); bit 0 is cin.
    function automatic logic [LF_WIDTH:0] lf_carries(
        input logic [LF_WIDTH-1:0] g_pfx,
        input logic [LF_WIDTH-1:0] p_pfx,
        input logic                cin
    );
        return {g_pfx | (p_pfx & {LF_WIDTH{cin}}), cin};
    endfunction

endpackage

// File: rtl/lf_skid_fifo2.sv
// Two-entry register FIFO with valid/ready handshakes on both sides.
// in_ready depends only on the registered occupancy, never on out_ready.
module lf_skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   cnt_reg;
    logic [1:0]   cnt_next;
    logic         wr_ptr_reg;
    logic         rd_ptr_reg;
    logic [W-1:0] mem_reg [2];
    logic         push;
    logic         pop;

    assign in_ready  = rst_n & (cnt_reg != 2'd2);
    assign out_valid = (cnt_reg != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        cnt_next = cnt_reg + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    mem_reg[gi] <= '0;
                else if (push && (wr_ptr_reg == 1'(gi)))
                    mem_reg[gi] <= in_data;
            end
        end
    endgenerate

    // Blank the payload when empty so drained entries never leak onto the outputs.
    assign out_data = out_valid ? mem_reg[rd_ptr_reg] : '0;

endmodule

// File: rtl/lf_sum_stage.sv
// Final stage of the Ladner-Fischer adder: recovers carries from the prefix
// vectors, forms sum and flags, and buffers the result in a 2-entry FIFO.
module lf_sum_stage
    import lf_adder_pkg::*;
#(
    parameter int WIDTH = LF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g_pfx,
    input  logic [WIDTH-1:0] p_pfx,
    input  logic [WIDTH-1:0] h,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;
    logic             cout_comb;
    logic             ovf_comb;
    logic             zero_comb;
    logic [WIDTH+2:0] payload_in;
    logic [WIDTH+2:0] payload_out;

    genvar gi;
    generate
        if (WIDTH == LF_WIDTH) begin : g_pkg_carry
            assign carry = lf_carries(g_pfx, p_pfx, cin);
        end else begin : g_bit_carry
            assign carry[0] = cin;
            for (gi = 1; gi <= WIDTH; gi++) begin : g_c
                assign carry[gi] = g_pfx[gi-1] | (p_pfx[gi-1] & cin);
            end
        end
    endgenerate

    assign sum_comb   = h ^ carry[WIDTH-1:0];
    assign cout_comb  = carry[WIDTH];
    assign ovf_comb   = carry[WIDTH] ^ carry[WIDTH-1];
    assign zero_comb  = ~|sum_comb;
    assign payload_in = {sum_comb, cout_comb, ovf_comb, zero_comb};

    lf_skid_fifo2 #(
        .W(WIDTH + 3)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (payload_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (payload_out)
    );

    assign {sum, cout, ovf, zero} = payload_out;

endmodule

// File: tb/tb_lf_sum_stage.sv
// Randomized self-checking bench for lf_sum_stage at WIDTH=8, scored against
// an a+b+cin arithmetic model and a queue of outstanding results.
module tb_lf_sum_stage;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] g_pfx = '0;
    logic [W-1:0] p_pfx = '0;
    logic [W-1:0] h = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;

    int n_vec = 0;
    int n_bad = 0;
    logic [W+2:0] sb [$];

    always #5 clk = ~clk;

    lf_sum_stage #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .g_pfx    (g_pfx),
        .p_pfx    (p_pfx),
        .h        (h),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .zero     (zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {sum,cout,ovf,zero} straight from integer addition.
    function automatic logic [W+2:0] ref_result(input int a, input int b, input int ci);
        int full;
        logic [W-1:0] s;
        logic v;
        full = a + b + ci;
        s = full[W-1:0];
        v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {s, full[W] == 1'b1, v, s == '0};
    endfunction

    // Prefix-network view of a,b: group generate = carry out of bits 0..i with
    // no carry-in; group propagate = every half-sum bit in 0..i is set.
    task automatic drive_op(input int a, input int b, input int ci);
        int m;
        for (int i = 0; i < W; i++) begin
            m = (1 << (i + 1)) - 1;
            g_pfx[i] = (((a & m) + (b & m)) >> (i + 1)) & 1;
            p_pfx[i] = (((a ^ b) & m) == m);
        end
        h   = W'(a ^ b);
        cin = ci[0];
    endtask

    // One clock cycle: drive, observe just after the falling edge, score.
    task automatic step(input logic v, input int a, input int b, input int ci,
                        input logic rdy, output logic accepted);
        @(negedge clk);
        in_valid  = v;
        out_ready = rdy;
        drive_op(a, b, ci);
        #1;
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
        if (out_valid && sb.size() != 0)
            chk("head", 64'({sum, cout, ovf, zero}), 64'(sb[0]));
        if (out_valid && out_ready && sb.size() != 0)
            void'(sb.pop_front());
        accepted = in_valid & in_ready;
        if (accepted)
            sb.push_back(ref_result(a, b, ci));
    endtask

    task automatic send(input int a, input int b, input int ci, input logic rdy, output int tries);
        logic acc;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 20) begin
            step(1'b1, a, b, ci, rdy, acc);
            tries++;
        end
        if (!acc) chk("send_timeout", 64'(tries), 64'(0));
    endtask

    task automatic drain();
        logic acc;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step(1'b0, 0, 0, 0, 1'b1, acc);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        logic acc;
        int   tries;
        int   a, b, ci;

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_sum", 64'({sum, cout, ovf, zero}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases from the arithmetic rules.
        send(8'hFF, 8'h01, 0, 1'b1, tries);
        step(1'b0, 0, 0, 0, 1'b1, acc);
        chk("wrap_lat", 64'(sb.size()), 64'(0));
        send(8'h7F, 8'h01, 0, 1'b1, tries);
        step(1'b0, 0, 0, 0, 1'b1, acc);
        send(8'h0F, 8'hF0, 1, 1'b1, tries);
        step(1'b0, 0, 0, 0, 1'b1, acc);
        chk("const_wrap", 64'(ref_result(8'hFF, 8'h01, 0)), 64'({8'h00, 3'b101}));
        chk("const_ovf", 64'(ref_result(8'h7F, 8'h01, 0)), 64'({8'h80, 3'b010}));

        // Backpressure: two fill the buffer, the third waits for the first pop.
        step(1'b1, 8'h11, 8'h22, 0, 1'b0, acc);
        step(1'b1, 8'h33, 8'h44, 1, 1'b0, acc);
        step(1'b1, 8'h80, 8'h80, 0, 1'b0, acc);
        chk("bp_third_blocked", 64'(acc), 64'(0));
        step(1'b1, 8'h80, 8'h80, 0, 1'b0, acc);
        send(8'h80, 8'h80, 0, 1'b1, tries);
        chk("bp_third_latency", 64'(tries), 64'(2));
        drain();

        // Full-rate streaming: buffer must never fill.
        for (int i = 0; i < 100; i++) begin
            step(1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 1), 1'b1, acc);
            chk("stream_accept", 64'(acc), 64'(1));
        end
        drain();

        // Random valid/ready mix.
        for (int i = 0; i < 300; i++) begin
            a  = $urandom_range(0, 255);
            b  = $urandom_range(0, 255);
            ci = $urandom_range(0, 1);
            step(1'($urandom_range(0, 1)), a, b, ci, 1'($urandom_range(0, 1)), acc);
        end
        drain();

        // Asynchronous reset with the buffer full.
        step(1'b1, 8'h12, 8'h34, 0, 1'b0, acc);
        step(1'b1, 8'h56, 8'h78, 1, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_in_ready", 64'(in_ready), 64'(0));
        chk("arst_payload", 64'({sum, cout, ovf, zero}), 64'(0));
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 0, 0, 0, 1'b1, acc);
        send(8'hA5, 8'h5A, 1, 1'b1, tries);
        chk("post_rst_first_try", 64'(tries), 64'(1));
        drain();
        step(1'b0, 0, 0, 0, 1'b1, acc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
